stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control sequencer for the stopwatch datapath (BCD digit counter plus multiplexed seven-segment display).
- Conditions three raw pushbuttons: start/stop, clear and lap.
- Runs the run/pause/lap state machine.
- Generates the centisecond count-enable tick, the counter clear pulse, and a display-freeze level for lap/split.
- Sits between the board buttons and the counter/display blocks; it is the only source of count_en and count_clr.

Parameters:
CLK_HZ, 100_000_000, input clock frequency in Hz.
TICK_HZ, 100, count_en rate while running (centiseconds); DIV = CLK_HZ/TICK_HZ, integer, >= 2.
DB_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); >= 2.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high; clears all state.
btn_start_stop  input  1  raw asynchronous pushbutton, high = pressed.
btn_clear  input  1  raw asynchronous pushbutton, high = pressed.
btn_lap  input  1  raw asynchronous pushbutton, high = pressed.
count_en  output  1  one-cycle pulse; counter advances one centisecond.
count_clr  output  1  one-cycle pulse; counter returns to 00.00.
disp_hold  output  1  level; display latch keeps its current value while high.
state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 LAP.

Behaviour:
- Reset (sync, high):
  - state=IDLE; count_en=0, count_clr=0, disp_hold=0.
  - Synchronizers, debounced levels, debounce counters and prescaler all cleared to 0.
  - Reset mid-run or mid-debounce aborts everything; no pulse is emitted in the cycle after reset.
- Button conditioning, per button, independent:
  - 2-flop synchronizer, then debounce counter.
  - Counter resets to 0 whenever the synced value equals the debounced level, and increments otherwise.
  - When the counter is at DB_CYCLES-1 and the values still differ, the debounced level takes the synced value and the counter clears.
  - A rising edge of the debounced level produces a registered one-cycle press pulse.
  - Latency: exactly DB_CYCLES+3 clocks from the first edge sampling raw high to the press pulse being high.
  - Glitches shorter than DB_CYCLES produce no pulse.
  - Release is debounced the same way and produces no pulse.
- Press priority when pulses coincide: clear > start_stop > lap.
  - A press that is ignored in the current state lets the next-priority press act.
  - At most one transition per cycle.
- FSM (transition on the edge where the press pulse is high):
  - IDLE: start_stop -> RUN. Clear -> IDLE and pulse count_clr again. Lap is ignored.
  - RUN: start_stop -> PAUSE. Lap -> LAP. Clear is ignored.
  - LAP: start_stop -> PAUSE. Lap -> RUN. Clear is ignored.
  - PAUSE: start_stop -> RUN. Clear -> IDLE. Lap is ignored.
- Outputs:
  - disp_hold=1 iff state==LAP. It is registered together with state.
  - count_clr pulses for one cycle, coincident with the first cycle of the IDLE entry caused by clear.
- Prescaler, width clog2(DIV):
  - Counts 0..DIV-1 only in RUN or LAP; holds its value in PAUSE, so the sub-tick fraction is preserved on resume.
  - Cleared together with count_clr, and by reset.
  - count_en is high for the one cycle in which the prescaler==DIV-1 while in RUN/LAP. The prescaler wraps to 0 on that edge.
  - count_en is never high in IDLE or PAUSE, including the cycle the state leaves RUN/LAP.
  - First count_en after IDLE->RUN occurs DIV cycles after the RUN entry.
  - LAP freezes only the display; counting continues at the same rate.
- A button held continuously generates exactly one press.

Test Plan:
- Bench parameters CLK_HZ=1000, TICK_HZ=100 (DIV=10), DB_CYCLES=4.
- Reset, then raw start_stop high for 20 cycles -> press pulse at cycle 7 (DB_CYCLES+3); state 00->01. count_en pulses every 10 cycles, first pulse 10 cycles after RUN entry.
- Raw start_stop glitch high for 3 cycles -> no press, state unchanged. Bounce pattern 1,0,1,1,1,1,1 -> exactly one press, 4 stable cycles after the last 0.
- In RUN with prescaler=6, press start_stop -> PAUSE, count_en stays 0. Press start_stop again -> RUN, next count_en exactly 4 cycles (prescaler 6->9) after resume.
- RUN, press lap -> state 11, disp_hold=1, count_en continues every 10 cycles. Press lap -> state 01, disp_hold=0. Press clear in RUN or LAP -> ignored, no count_clr.
- PAUSE, clear and start_stop pulses coincident -> IDLE, one count_clr pulse, prescaler 0. Assert reset during RUN with debounce in progress -> next cycle state 00, all outputs 0, no spurious press.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: conditions three pushbuttons, runs the run/pause/lap
// state machine and issues the centisecond count enable, counter clear and display hold.
module stopwatch_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic       count_en,
  output logic       count_clr,
  output logic       disp_hold,
  output logic [1:0] state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int DW  = $clog2(DB_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);

  localparam int B_CLR = 0;
  localparam int B_SS  = 1;
  localparam int B_LAP = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] press;

  assign raw = {btn_lap, btn_start_stop, btn_clear};

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples pre-edge values and the synchronizer chain really is two stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-button debounce: the level only moves after DB_CYCLES consecutive disagreeing samples.
  for (genvar gi = 0; gi < 3; gi++) begin : g_db
    logic [DW-1:0] cnt;
    logic          level;
    logic          level_q;
    logic          press_r;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt     <= '0;
        level   <= 1'b0;
        level_q <= 1'b0;
        press_r <= 1'b0;
      end else begin
        level_q <= level;
        press_r <= level & ~level_q;
        if (sync2[gi] == level) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          level <= sync2[gi];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[gi] = press_r;
  end

  state_t        state_q;
  state_t        next_state;
  logic          clr_hit;
  logic          running;
  logic [PW-1:0] presc;

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state_q;
    clr_hit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press[B_CLR])     clr_hit    = 1'b1;
        else if (press[B_SS]) next_state = RUN;
      end
      RUN: begin
        if (press[B_SS])       next_state = PAUSE;
        else if (press[B_LAP]) next_state = LAP;
      end
      LAP: begin
        if (press[B_SS])       next_state = PAUSE;
        else if (press[B_LAP]) next_state = RUN;
      end
      PAUSE: begin
        if (press[B_CLR]) begin
          next_state = IDLE;
          clr_hit    = 1'b1;
        end else if (press[B_SS]) begin
          next_state = RUN;
        end
      end
    endcase
  end

  // The prescaler only advances on edges where we are counting both before and
  // after, so entry and exit edges neither advance it nor fire count_en.
  assign running = (state_q == RUN || state_q == LAP) &&
                   (next_state == RUN || next_state == LAP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      disp_hold <= 1'b0;
      count_clr <= 1'b0;
      count_en  <= 1'b0;
      presc     <= '0;
    end else begin
      state_q   <= next_state;
      disp_hold <= (next_state == LAP);
      count_clr <= clr_hit;
      count_en  <= 1'b0;
      if (clr_hit) begin
        presc <= '0;
      end else if (running) begin
        if (presc == PRE_LAST) begin
          presc    <= '0;
          count_en <= 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10 and DB_CYCLES=4; all expected
// timings are hand-derived from the button latency (7 edges) and tick period (10 edges).
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  localparam int B_CLR = 0;
  localparam int B_SS  = 1;
  localparam int B_LAP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap = 1'b0;
  logic       count_en;
  logic       count_clr;
  logic       disp_hold;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_ctrl #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .DB_CYCLES(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_start_stop(btn_start_stop),
    .btn_clear     (btn_clear),
    .btn_lap       (btn_lap),
    .count_en      (count_en),
    .count_clr     (count_clr),
    .disp_hold     (disp_hold),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_CLR:   btn_clear = v;
      B_SS:    btn_start_stop = v;
      default: btn_lap = v;
    endcase
  endtask

  // Press lands 7 edges after raw goes high; the state moves on the 8th.
  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick(8);
    set_btn(b, 1'b0);
  endtask

  task automatic wait_cen();
    int  n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 15) begin
      tick(1);
      n++;
      seen = count_en;
    end
    check("wait_count_en", seen, 1'b1);
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_state", state, S_IDLE);
    check("rst_cen", count_en, 1'b0);
    check("rst_clr", count_clr, 1'b0);
    check("rst_hold", disp_hold, 1'b0);
    reset = 1'b0;
    tick(2);

    // Start: 20-cycle hold, RUN entry on the 8th edge, count_en 10 and 20 edges later
    btn_start_stop = 1'b1;
    tick(7);
    check("start_before", state, S_IDLE);
    tick(1);
    check("start_run", state, S_RUN);
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 12) btn_start_stop = 1'b0;
      check("cen_first", count_en, (i == 10 || i == 20));
    end
    tick(4);
    check("release_no_press", state, S_RUN);

    // 3-cycle glitch is filtered
    btn_start_stop = 1'b1;
    tick(3);
    btn_start_stop = 1'b0;
    tick(10);
    check("glitch", state, S_RUN);

    // Bounce 1,0,1,1,1,1,1 then held: exactly one press
    btn_start_stop = 1'b1; tick(1);
    btn_start_stop = 1'b0; tick(1);
    btn_start_stop = 1'b1; tick(5);
    tick(2);
    check("bounce_before", state, S_RUN);
    tick(1);
    check("bounce_pause", state, S_PAUSE);
    tick(10);
    check("bounce_held", state, S_PAUSE);
    btn_start_stop = 1'b0;
    tick(8);
    check("bounce_release", state, S_PAUSE);

    press(B_SS);
    check("resume1", state, S_RUN);
    tick(8);

    // Pause with prescaler=6, then resume: count_en 4 edges after resume
    wait_cen();
    tick(9);
    btn_start_stop = 1'b1;
    tick(1);
    check("cen_pre_pause", count_en, 1'b1);
    tick(6);
    check("pre_pause_state", state, S_RUN);
    tick(1);
    check("pause_state", state, S_PAUSE);
    check("pause_edge_cen", count_en, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      if (i == 4) btn_start_stop = 1'b0;
      check("cen_paused", count_en, 1'b0);
    end
    check("still_paused", state, S_PAUSE);
    btn_start_stop = 1'b1;
    tick(8);
    check("resume_state", state, S_RUN);
    check("resume_edge_cen", count_en, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      check("cen_resume", count_en, (i == 4));
    end
    btn_start_stop = 1'b0;
    tick(8);

    // Lap: hold display, counting continues
    press(B_LAP);
    check("lap_state", state, S_LAP);
    check("lap_hold", disp_hold, 1'b1);
    wait_cen();
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      check("cen_lap", count_en, (i == 10));
    end
    btn_clear = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      check("clr_ignored_lap", count_clr, 1'b0);
    end
    btn_clear = 1'b0;
    check("lap_after_clr", state, S_LAP);
    tick(8);
    press(B_LAP);
    check("unlap_state", state, S_RUN);
    check("unlap_hold", disp_hold, 1'b0);
    tick(8);
    btn_clear = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      check("clr_ignored_run", count_clr, 1'b0);
    end
    btn_clear = 1'b0;
    check("run_after_clr", state, S_RUN);
    tick(8);

    // PAUSE with coincident clear and start_stop: clear wins
    press(B_SS);
    check("pause2", state, S_PAUSE);
    tick(8);
    btn_clear = 1'b1;
    btn_start_stop = 1'b1;
    tick(7);
    check("coinc_before", state, S_PAUSE);
    check("coinc_before_clr", count_clr, 1'b0);
    tick(1);
    check("coinc_idle", state, S_IDLE);
    check("coinc_clr", count_clr, 1'b1);
    tick(1);
    check("coinc_clr_once", count_clr, 1'b0);
    tick(5);
    btn_clear = 1'b0;
    btn_start_stop = 1'b0;
    tick(8);
    check("coinc_held", state, S_IDLE);

    // Clear in IDLE pulses count_clr again
    btn_clear = 1'b1;
    tick(8);
    check("idle_clr", count_clr, 1'b1);
    check("idle_clr_state", state, S_IDLE);
    tick(1);
    check("idle_clr_once", count_clr, 1'b0);
    btn_clear = 1'b0;
    tick(8);

    // Prescaler was cleared: first count_en exactly 10 edges after RUN entry
    btn_start_stop = 1'b1;
    tick(8);
    check("restart", state, S_RUN);
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (i == 1) btn_start_stop = 1'b0;
      check("cen_after_clear", count_en, (i == 10));
    end
    tick(8);

    // Reset mid-run with a debounce in flight
    btn_start_stop = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("mid_rst_state", state, S_IDLE);
    check("mid_rst_cen", count_en, 1'b0);
    check("mid_rst_clr", count_clr, 1'b0);
    check("mid_rst_hold", disp_hold, 1'b0);
    reset = 1'b0;
    btn_start_stop = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      check("post_rst_idle", state, S_IDLE);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
